// File: rtl/dds_pkg.sv
// Shared constants for the DDS front-panel parameter controller:
// field-select codes and the widths of the three editable words.
package dds_pkg;
  localparam logic [1:0] SEL_F1 = 2'd0;
  localparam logic [1:0] SEL_F2 = 2'd1;
  localparam logic [1:0] SEL_P2 = 2'd2;

  localparam int FW1_W = 6;
  localparam int FW2_W = 8;
  localparam int PW2_W = 9;
endpackage

// File: rtl/key_debounce.sv
// One front-panel key: 2-FF synchronizer, stable-level debounce counter and
// a one-cycle press pulse on the debounced 1->0 transition (keys are active-low).
module key_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic press,
  output logic level
);
  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          deb;
  logic          deb_q;
  logic          armed;
  logic [CW-1:0] cnt;

  // Until a stable release has been seen after reset the key is ignored, so a
  // key held through reset release cannot produce a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      deb   <= 1'b1;
      deb_q <= 1'b1;
      armed <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      deb_q <= deb;
      if (!armed) begin
        if (!sync2) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          armed <= 1'b1;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (sync2 != deb) begin
        if (cnt == LAST) begin
          deb <= sync2;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign press = deb_q & ~deb;
  assign level = deb;
endmodule

// File: rtl/dds_param_ctrl.sv
// DDS front-panel parameter controller: debounced keys, field-select FSM and
// wrap-around edit of Fword1/Fword2/Pword2. Optional macro AUTO_REPEAT_EN
// adds hold-to-repeat on the up/down keys.
module dds_param_ctrl
  import dds_pkg::*;
#(
  parameter int               DEB_CYCLES    = 1000000,
  parameter logic [FW1_W-1:0] FW1_INIT      = 6'd1,
  parameter logic [FW2_W-1:0] FW2_INIT      = 8'd1,
  parameter logic [PW2_W-1:0] PW2_INIT      = 9'd0,
  parameter logic [PW2_W-1:0] PW2_MAX       = 9'd359,
  parameter int               REPEAT_DELAY  = 25000000,
  parameter int               REPEAT_PERIOD = 5000000
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             key_sel,
  input  logic             key_up,
  input  logic             key_down,
  output logic [FW1_W-1:0] Fword1,
  output logic [FW2_W-1:0] Fword2,
  output logic [PW2_W-1:0] Pword2,
  output logic [1:0]       sel_field,
  output logic             param_update
);
  logic       sel_press, up_press, down_press;
  logic       up_ev, down_ev;
  logic [2:0] key_level;
  logic       unused_level;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_sel (
    .clk(sys_clk), .rst_n(sys_rst), .key(key_sel), .press(sel_press), .level(key_level[0])
  );
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_up (
    .clk(sys_clk), .rst_n(sys_rst), .key(key_up), .press(up_press), .level(key_level[1])
  );
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_down (
    .clk(sys_clk), .rst_n(sys_rst), .key(key_down), .press(down_press), .level(key_level[2])
  );

  assign unused_level = ^key_level;

`ifdef AUTO_REPEAT_EN
  logic [31:0] rpt_cnt [2];
  logic [1:0]  rpt_started;
  logic [1:0]  rpt_pulse;
  logic [1:0]  rpt_level;

  assign rpt_level = key_level[2:1];

  // Index 0 repeats the up key, index 1 the down key; the first extra pulse
  // comes after REPEAT_DELAY held cycles, later ones every REPEAT_PERIOD.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      for (int i = 0; i < 2; i++) rpt_cnt[i] <= '0;
      rpt_started <= '0;
      rpt_pulse   <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        rpt_pulse[i] <= 1'b0;
        if (rpt_level[i]) begin
          rpt_cnt[i]     <= '0;
          rpt_started[i] <= 1'b0;
        end else if (rpt_cnt[i] == (rpt_started[i] ? 32'(REPEAT_PERIOD - 1)
                                                   : 32'(REPEAT_DELAY - 1))) begin
          rpt_pulse[i]   <= 1'b1;
          rpt_started[i] <= 1'b1;
          rpt_cnt[i]     <= '0;
        end else begin
          rpt_cnt[i] <= rpt_cnt[i] + 32'd1;
        end
      end
    end
  end

  assign up_ev   = up_press | rpt_pulse[0];
  assign down_ev = down_press | rpt_pulse[1];
`else
  localparam int unused_rpt = REPEAT_DELAY + REPEAT_PERIOD;
  assign up_ev   = up_press;
  assign down_ev = down_press;
`endif

  function automatic logic [1:0] next_field(input logic [1:0] cur);
    case (cur)
      SEL_F1:  return SEL_F2;
      SEL_F2:  return SEL_P2;
      default: return SEL_F1;
    endcase
  endfunction

  // param_update is a strobe, high for exactly the cycle in which an edited
  // word first shows its new value; there is no handshake back from the sink.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      Fword1       <= FW1_INIT;
      Fword2       <= FW2_INIT;
      Pword2       <= PW2_INIT;
      sel_field    <= SEL_F1;
      param_update <= 1'b0;
    end else begin
      param_update <= 1'b0;
      if (sel_press) begin
        sel_field <= next_field(sel_field);
      end else if (sel_field == 2'd3) begin
        sel_field <= SEL_F1;
      end else if (up_ev ^ down_ev) begin
        param_update <= 1'b1;
        case (sel_field)
          SEL_F1: Fword1 <= up_ev ? Fword1 + 1'b1 : Fword1 - 1'b1;
          SEL_F2: Fword2 <= up_ev ? Fword2 + 1'b1 : Fword2 - 1'b1;
          default: begin
            if (up_ev) Pword2 <= (Pword2 == PW2_MAX) ? '0 : Pword2 + 1'b1;
            else       Pword2 <= (Pword2 == '0) ? PW2_MAX : Pword2 - 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dds_param_ctrl.sv
// Bench for dds_param_ctrl: directed and random key presses against a
// high-level model; expected words are queued and popped on param_update.
module tb_dds_param_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_sel, key_up, key_down;
  logic [5:0] Fword1;
  logic [7:0] Fword2;
  logic [8:0] Pword2;
  logic [1:0] sel_field;
  logic       param_update;

  always #5 clk = ~clk;

  dds_param_ctrl #(
    .DEB_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
  ) dut (
    .sys_clk(clk), .sys_rst(rst_n), .key_sel(key_sel), .key_up(key_up),
    .key_down(key_down), .Fword1(Fword1), .Fword2(Fword2), .Pword2(Pword2),
    .sel_field(sel_field), .param_update(param_update)
  );

  int          fw1, fw2, pw2, sel_m;
  logic [22:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          rpt_mode = 0;
  int          rpt_count = 0;

  function automatic logic [22:0] model_word();
    logic [5:0] a;
    logic [7:0] b;
    logic [8:0] c;
    a = fw1[5:0];
    b = fw2[7:0];
    c = pw2[8:0];
    return {a, b, c};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    fw1 = 1; fw2 = 1; pw2 = 0; sel_m = 0;
  endtask

  task automatic model_apply(input bit s, input bit u, input bit d);
    int delta;
    if (s) begin
      sel_m = (sel_m + 1) % 3;
    end else if (u != d) begin
      delta = u ? 1 : -1;
      case (sel_m)
        0: fw1 = (fw1 + delta + 64) % 64;
        1: fw2 = (fw2 + delta + 256) % 256;
        default: pw2 = (pw2 + delta + 360) % 360;
      endcase
      exp_q.push_back(model_word());
    end
  endtask

  task automatic press(input bit s, input bit u, input bit d);
    model_apply(s, u, d);
    key_sel = ~s; key_up = ~u; key_down = ~d;
    cycles(20);
    key_sel = 1'b1; key_up = 1'b1; key_down = 1'b1;
    cycles(20);
  endtask

  task automatic do_reset();
    key_sel = 1'b1; key_up = 1'b1; key_down = 1'b1;
    rst_n = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic check_words(input string tag);
    check({tag, " Fword1"}, Fword1, fw1);
    check({tag, " Fword2"}, Fword2, fw2);
    check({tag, " Pword2"}, Pword2, pw2);
    check({tag, " sel_field"}, sel_field, sel_m);
  endtask

  // Monitor: every update strobe must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && param_update === 1'b1) begin
      if (rpt_mode) begin
        rpt_count++;
      end else if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_update: got F1=%0d F2=%0d P2=%0d expected no update",
                 Fword1, Fword2, Pword2);
      end else begin
        logic [22:0] e;
        e = exp_q.pop_front();
        check("update_words", {Fword1, Fword2, Pword2}, e);
      end
    end
  end

  initial begin
    logic [2:0] m;
    int         start_fw1;
    key_sel = 1'b1; key_up = 1'b1; key_down = 1'b1;
    rst_n = 1'b1;
    model_reset();
    #2;
    rst_n = 1'b0;
    cycles(3);
    check("reset Fword1", Fword1, 1);
    check("reset param_update", param_update, 0);
    rst_n = 1'b1;
    cycles(50);
    check_words("idle");

    // Short glitches must be rejected, a clean press accepted once.
    for (int i = 0; i < 5; i++) begin
      key_up = 1'b0; cycles(1);
      key_up = 1'b1; cycles(3);
    end
    cycles(20);
    check("glitch Fword1", Fword1, 1);
    press(0, 1, 0);
    check_words("clean_up");

    for (int i = 0; i < 3; i++) begin
      press(1, 0, 0);
      check("sel_step", sel_field, sel_m);
    end
    press(1, 0, 0);
    press(1, 0, 0);
    press(0, 0, 1);
    check_words("pw2_down_wrap");
    press(0, 1, 0);
    check_words("pw2_up_wrap");

    press(1, 0, 0);
    for (int i = 0; i < 3; i++) press(0, 0, 1);
    check_words("fw1_63");
    press(0, 1, 0);
    check_words("fw1_wrap");
    press(1, 0, 0);
    press(0, 0, 1);
    press(0, 0, 1);
    check_words("fw2_wrap");

    press(0, 1, 1);
    check_words("up_down_same");
    press(1, 1, 0);
    check_words("sel_priority");

    for (int i = 0; i < 30; i++) begin
      m = 3'($urandom_range(0, 7));
      press(m[2], m[1], m[0]);
      check("rand sel_field", sel_field, sel_m);
    end
    check_words("random_end");
    check("queue_drained", exp_q.size(), 0);

    // Reset in the middle of a press, released while the key is still held.
    do_reset();
    cycles(10);
    press(1, 0, 0);
    for (int i = 0; i < 9; i++) press(0, 1, 0);
    check_words("fw2_10");
    key_up = 1'b0;
    cycles(3);
    rst_n = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    model_reset();
    cycles(30);
    check_words("held_through_reset");
    key_up = 1'b1;
    cycles(20);
    press(0, 1, 0);
    check_words("repress_after_reset");

`ifdef AUTO_REPEAT_EN
    cycles(10);
    start_fw1 = fw1;
    rpt_mode  = 1;
    rpt_count = 0;
    key_up = 1'b0;
    cycles(60);
    key_up = 1'b1;
    cycles(20);
    rpt_mode = 0;
    n_cmp++;
    if (rpt_count < 5 || rpt_count > 7) begin
      n_err++;
      $display("FAIL repeat_count: got %0d expected 5..7", rpt_count);
    end
    fw1 = (start_fw1 + rpt_count) % 64;
    check_words("repeat_value");
`else
    start_fw1 = fw1;
    key_up = 1'b0;
    model_apply(0, 1, 0);
    cycles(60);
    key_up = 1'b1;
    cycles(20);
    check("single_edit_on_hold", Fword1, (start_fw1 + 1) % 64);
`endif

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) cycles(1);
    check("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
